dm_lsu: RTL and testbench

Load/store initiator sitting between the pipeline MEM stage and the word-organised data memory. Accepts one byte/halfword/word access per request, converts it into one or two aligned 32-bit memory transactions with byte enables (splitting accesses that straddle a word boundary), and returns sign- or zero-extended load data. Stalls the pipeline while an access is in flight.

---
 rtl/dm_pkg.sv | 12 +
 rtl/dm_lane_align.sv | 31 +++
 rtl/dm_lsu.sv | 94 +++++++++
 tb/tb_dm_lsu.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// dm_pkg: shared access-type codes, FSM state encoding and type-legality helper for dm_lsu
package dm_pkg;
   localparam logic [2:0] DM_WORD   = 3'd0;
   localparam logic [2:0] DM_HALF   = 3'd1;
   localparam logic [2:0] DM_HALF_U = 3'd2;
   localparam logic [2:0] DM_BYTE   = 3'd3;
   localparam logic [2:0] DM_BYTE_U = 3'd4;
   typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} dm_state_e;
   function automatic logic dm_legal(input logic [2:0] t);
      return t <= DM_BYTE_U;
   endfunction
endpackage

// File: rtl/dm_lane_align.sv
// dm_lane_align: byte-lane alignment for the load/store unit
// Ports: off/typ select offset and size; wdata in, wlanes/mask out for stores;
//        rword {hi,lo} in, rdata out (shifted and extended) for loads; split flags a word-straddling access.
module dm_lane_align
   import dm_pkg::*;
(
   input  logic [1:0]  off,
   input  logic [2:0]  typ,
   input  logic [31:0] wdata,
   input  logic [63:0] rword,
   output logic        split,
   output logic [7:0]  mask,
   output logic [63:0] wlanes,
   output logic [31:0] rdata
);
   logic [2:0]  size;
   logic [3:0]  smask;
   logic [31:0] rsh;
   always_comb begin
      size   = typ == DM_WORD ? 3'd4 : (typ == DM_HALF || typ == DM_HALF_U) ? 3'd2 : 3'd1;
      smask  = size == 3'd4 ? 4'hf : size == 3'd2 ? 4'h3 : 4'h1;
      split  = {1'b0, off} + size > 3'd4;
      mask   = {4'b0, smask} << off;
      wlanes = {32'b0, wdata} << {off, 3'b000};
      rsh    = 32'(rword >> {off, 3'b000});
      rdata  = typ == DM_HALF   ? {{16{rsh[15]}}, rsh[15:0]} :
               typ == DM_HALF_U ? {16'b0, rsh[15:0]} :
               typ == DM_BYTE   ? {{24{rsh[7]}}, rsh[7:0]} :
               typ == DM_BYTE_U ? {24'b0, rsh[7:0]} : rsh;
   end
endmodule

// File: rtl/dm_lsu.sv
// dm_lsu: load/store initiator splitting byte/half/word accesses into aligned 32-bit memory transactions
// Ports: req_* (MEM-stage request, req_ready handshake), rsp_* (one-cycle completion with data/err),
//        busy (pipeline stall), mem_* (word-organised memory, combinational mem_rdata).
module dm_lsu
   import dm_pkg::*;
#(
   parameter int AW = 32
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [AW-1:0] req_addr,
   input  logic [31:0]   req_wdata,
   input  logic [2:0]    req_type,
   output logic          rsp_valid,
   output logic [31:0]   rsp_rdata,
   output logic          rsp_err,
   output logic          busy,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [3:0]    mem_be,
   output logic [31:0]   mem_wdata,
   input  logic [31:0]   mem_rdata
);
   dm_state_e     state;
   logic          we_q;
   logic [AW-1:0] addr_q;
   logic [31:0]   wdata_q;
   logic [2:0]    typ_q;
   logic [31:0]   lo;
   logic [31:0]   hi;
   logic          split;
   logic [7:0]    mask;
   logic [63:0]   wlanes;
   logic [31:0]   ld_data;
   logic [AW-1:0] word_addr;
   dm_lane_align u_align (
      .off   (addr_q[1:0]),
      .typ   (typ_q),
      .wdata (wdata_q),
      .rword ({hi, lo}),
      .split (split),
      .mask  (mask),
      .wlanes(wlanes),
      .rdata (ld_data)
   );
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= IDLE;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         typ_q   <= '0;
         lo      <= '0;
         hi      <= '0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               we_q    <= req_we;
               addr_q  <= req_addr;
               wdata_q <= req_wdata;
               typ_q   <= req_type;
               state   <= dm_legal(req_type) ? ACC0 : RESP;
            end
            ACC0: begin
               if (!we_q) lo <= mem_rdata;
               state <= split ? ACC1 : RESP;
            end
            ACC1: begin
               if (!we_q) hi <= mem_rdata;
               state <= RESP;
            end
            default: state <= IDLE;
         endcase
      end
   end
   // Memory side is decoded from state and latched request only; address wraps naturally at AW bits.
   assign word_addr = {addr_q[AW-1:2], 2'b00};
   always_comb begin
      mem_en    = state == ACC0 || state == ACC1;
      mem_we    = mem_en & we_q;
      mem_addr  = state == ACC1 ? word_addr + AW'(4) : state == ACC0 ? word_addr : '0;
      mem_be    = state == ACC1 ? mask[7:4] : state == ACC0 ? mask[3:0] : 4'b0;
      mem_wdata = state == ACC1 ? wlanes[63:32] : state == ACC0 ? wlanes[31:0] : 32'b0;
      rsp_valid = state == RESP;
      rsp_err   = rsp_valid & ~dm_legal(typ_q);
      rsp_rdata = (rsp_valid & ~we_q & dm_legal(typ_q)) ? ld_data : 32'b0;
      busy      = state != IDLE;
      req_ready = state == IDLE && rstn;
   end
endmodule

// File: tb/tb_dm_lsu.sv
// tb_dm_lsu: directed self-checking bench for dm_lsu with a 64-word behavioural memory
module tb_dm_lsu;
   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [2:0]  req_type = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        busy;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic [31:0] mem [64] = '{default: 32'h0};
   int          tests = 0;
   int          fails = 0;
   int          lat;
   int          nacc;
   logic [31:0] acc_addr [2];
   logic [3:0]  acc_be [2];
   logic [31:0] acc_wd [2];
   logic [31:0] rd;
   logic        er;

   dm_lsu dut (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_type(req_type),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;
   assign mem_rdata = mem[mem_addr[7:2]];
   always @(posedge clk)
      if (mem_en && mem_we)
         for (int i = 0; i < 4; i++)
            if (mem_be[i]) mem[mem_addr[7:2]][8*i +: 8] <= mem_wdata[8*i +: 8];

   task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] t);
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_type = t;
      for (int k = 0; k < 20 && !req_ready; k++) @(negedge clk);
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0; nacc = 0; rd = 'x; er = 'x;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (mem_en && nacc < 2) begin
            acc_addr[nacc] = mem_addr; acc_be[nacc] = mem_be; acc_wd[nacc] = mem_wdata;
            nacc++;
         end
         if (rsp_valid) begin
            lat = k; rd = rsp_rdata; er = rsp_err;
            break;
         end
      end
   endtask

   task automatic test_reset;
      #2;
      tests++; if (req_ready !== 1'b0) begin $display("FAIL rst_ready got %b exp 0", req_ready); fails++; end
      tests++; if ({busy, mem_en, mem_we, rsp_valid, rsp_err} !== 5'b0) begin $display("FAIL rst_ctl got %b exp 00000", {busy, mem_en, mem_we, rsp_valid, rsp_err}); fails++; end
      tests++; if ({mem_addr, mem_be, mem_wdata, rsp_rdata} !== '0) begin $display("FAIL rst_data got %h/%h/%h/%h exp 0", mem_addr, mem_be, mem_wdata, rsp_rdata); fails++; end
      @(negedge clk); rstn = 1'b1; #1;
      tests++; if (req_ready !== 1'b1) begin $display("FAIL rel_ready got %b exp 1", req_ready); fails++; end
   endtask

   task automatic test_word;
      do_req(1'b1, 32'h10, 32'hDEADBEEF, 3'd0);
      tests++; if (nacc !== 1 || acc_be[0] !== 4'hf || acc_addr[0] !== 32'h10 || acc_wd[0] !== 32'hDEADBEEF) begin $display("FAIL sw_acc got n=%0d be=%b a=%h d=%h exp 1 1111 10 deadbeef", nacc, acc_be[0], acc_addr[0], acc_wd[0]); fails++; end
      tests++; if (lat !== 2 || rd !== 32'h0 || er !== 1'b0) begin $display("FAIL sw_rsp got lat=%0d rd=%h err=%b exp 2 0 0", lat, rd, er); fails++; end
      tests++; if (mem[4] !== 32'hDEADBEEF) begin $display("FAIL sw_mem got %h exp deadbeef", mem[4]); fails++; end
      do_req(1'b0, 32'h10, 32'h0, 3'd0);
      tests++; if (lat !== 2 || rd !== 32'hDEADBEEF || er !== 1'b0 || nacc !== 1) begin $display("FAIL lw got lat=%0d rd=%h err=%b n=%0d exp 2 deadbeef 0 1", lat, rd, er, nacc); fails++; end
   endtask

   task automatic test_byte;
      do_req(1'b1, 32'h20, 32'h11223344, 3'd0);
      do_req(1'b1, 32'h23, 32'h12345680, 3'd3);
      tests++; if (acc_be[0] !== 4'b1000 || acc_addr[0] !== 32'h20 || acc_wd[0] !== 32'h80000000) begin $display("FAIL sb_acc got be=%b a=%h d=%h exp 1000 20 80000000", acc_be[0], acc_addr[0], acc_wd[0]); fails++; end
      tests++; if (mem[8] !== 32'h80223344) begin $display("FAIL sb_mem got %h exp 80223344", mem[8]); fails++; end
      do_req(1'b0, 32'h23, 32'h0, 3'd3);
      tests++; if (rd !== 32'hFFFFFF80 || lat !== 2) begin $display("FAIL lb got %h lat=%0d exp ffffff80 2", rd, lat); fails++; end
      do_req(1'b0, 32'h23, 32'h0, 3'd4);
      tests++; if (rd !== 32'h00000080) begin $display("FAIL lbu got %h exp 00000080", rd); fails++; end
      do_req(1'b0, 32'h21, 32'h0, 3'd1);
      tests++; if (rd !== 32'h00002233 || acc_be[0] !== 4'b0110) begin $display("FAIL lh_mid got %h be=%b exp 00002233 0110", rd, acc_be[0]); fails++; end
   endtask

   task automatic test_split;
      do_req(1'b1, 32'h13, 32'h0000A55A, 3'd1);
      tests++; if (nacc !== 2 || acc_addr[0] !== 32'h10 || acc_be[0] !== 4'b1000 || acc_wd[0] !== 32'h5A000000) begin $display("FAIL sh_acc0 got n=%0d a=%h be=%b d=%h exp 2 10 1000 5a000000", nacc, acc_addr[0], acc_be[0], acc_wd[0]); fails++; end
      tests++; if (acc_addr[1] !== 32'h14 || acc_be[1] !== 4'b0001 || acc_wd[1] !== 32'h000000A5) begin $display("FAIL sh_acc1 got a=%h be=%b d=%h exp 14 0001 000000a5", acc_addr[1], acc_be[1], acc_wd[1]); fails++; end
      tests++; if (lat !== 3 || mem[4] !== 32'h5AADBEEF || mem[5] !== 32'h000000A5) begin $display("FAIL sh_mem got lat=%0d %h %h exp 3 5aadbeef 000000a5", lat, mem[4], mem[5]); fails++; end
      do_req(1'b0, 32'h13, 32'h0, 3'd1);
      tests++; if (rd !== 32'hFFFFA55A || lat !== 3) begin $display("FAIL lh_split got %h lat=%0d exp ffffa55a 3", rd, lat); fails++; end
      do_req(1'b0, 32'h13, 32'h0, 3'd2);
      tests++; if (rd !== 32'h0000A55A) begin $display("FAIL lhu_split got %h exp 0000a55a", rd); fails++; end
   endtask

   task automatic test_wrap;
      do_req(1'b1, 32'hFFFFFFFC, 32'hBBAA9988, 3'd0);
      do_req(1'b1, 32'h00000000, 32'h77665544, 3'd0);
      do_req(1'b0, 32'hFFFFFFFE, 32'h0, 3'd0);
      tests++; if (acc_addr[0] !== 32'hFFFFFFFC || acc_be[0] !== 4'b1100) begin $display("FAIL wrap_acc0 got a=%h be=%b exp fffffffc 1100", acc_addr[0], acc_be[0]); fails++; end
      tests++; if (acc_addr[1] !== 32'h0 || acc_be[1] !== 4'b0011) begin $display("FAIL wrap_acc1 got a=%h be=%b exp 00000000 0011", acc_addr[1], acc_be[1]); fails++; end
      tests++; if (rd !== 32'h5544BBAA || lat !== 3) begin $display("FAIL wrap_rd got %h lat=%0d exp 5544bbaa 3", rd, lat); fails++; end
   endtask

   task automatic test_illegal;
      do_req(1'b0, 32'h10, 32'h0, 3'd6);
      tests++; if (nacc !== 0 || lat !== 1 || er !== 1'b1 || rd !== 32'h0) begin $display("FAIL illegal got n=%0d lat=%0d err=%b rd=%h exp 0 1 1 0", nacc, lat, er, rd); fails++; end
   endtask

   task automatic test_reset_acc1;
      bit seen;
      do_req(1'b1, 32'h20, 32'h0, 3'd0);
      do_req(1'b1, 32'h24, 32'h0, 3'd0);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h23; req_wdata = 32'h1234; req_type = 3'd1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      tests++; if (mem_en !== 1'b1 || mem_addr !== 32'h24) begin $display("FAIL racc1_pre got en=%b a=%h exp 1 24", mem_en, mem_addr); fails++; end
      rstn = 1'b0; #1;
      tests++; if ({busy, mem_en, mem_we, mem_be, rsp_valid, req_ready} !== 9'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin $display("FAIL racc1_out got %b a=%h d=%h exp 0", {busy, mem_en, mem_we, mem_be, rsp_valid, req_ready}, mem_addr, mem_wdata); fails++; end
      seen = 1'b0;
      repeat (2) @(negedge clk) seen |= rsp_valid;
      rstn = 1'b1;
      repeat (3) @(negedge clk) seen |= rsp_valid;
      tests++; if (seen !== 1'b0) begin $display("FAIL racc1_rsp got %b exp 0", seen); fails++; end
      tests++; if (mem[8] !== 32'h34000000 || mem[9] !== 32'h0) begin $display("FAIL racc1_mem got %h %h exp 34000000 00000000", mem[8], mem[9]); fails++; end
   endtask

   initial begin
      test_reset;
      test_word;
      test_byte;
      test_split;
      test_wrap;
      test_illegal;
      test_reset_acc1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
